// File: rtl/popcount_sequencer.sv
// popcount_sequencer
//
// Counts the ones in an in_data word of 7*N_CHUNKS bits. A single 7-input
// ones counter is reused once per clock. Each cycle it counts one 7-bit
// slice of a shift register, so a word takes N_CHUNKS cycles to count.
//
// Optional feature: define POPCOUNT_EARLY_EXIT_EN to end counting as soon as
// the slices not yet counted are all zero. Without the macro, every word takes
// exactly N_CHUNKS count cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    word to count (7*N_CHUNKS bits)
//   in_valid   in_data is valid
//   in_ready   block will accept in_data (only while IDLE)
//   out_count  ones count of the accepted word (RW bits)
//   out_valid  out_count is valid (held while DONE)
//   out_ready  consumer accepts out_count
//   busy       state is not IDLE

module popcount_sequencer #(
  parameter int N_CHUNKS = 4,
  localparam int W  = 7 * N_CHUNKS,
  localparam int RW = $clog2(W + 1),
  localparam int IW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [RW-1:0] out_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [2:0]    slice_ones;
  logic [W-1:0]  shift_next;
  logic          last_slice;
  logic          finish_count;

  // This is the only ones counter in the block. It counts the low 7-bit slice.
  function automatic logic [2:0] ones7(input logic [6:0] s);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'b00, s[i]};
    end
    return n;
  endfunction

  assign slice_ones = ones7(shift_q[6:0]);
  assign shift_next = shift_q >> 7;
  assign last_slice = (idx_q == IW'(N_CHUNKS - 1));

`ifdef POPCOUNT_EARLY_EXIT_EN
  // Stop once the slices still to be counted hold no ones.
  assign finish_count = last_slice || (shift_next == '0);
`else
  assign finish_count = last_slice;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // The sum cannot wrap: RW bits can hold 7*N_CHUNKS.
        acc_d   = acc_q + RW'(slice_ones);
        shift_d = shift_next;
        idx_d   = idx_q + IW'(1);
        if (finish_count) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Return to IDLE before taking the next word. This leaves one IDLE
        // cycle between words.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_count = acc_q;

endmodule
